// File: rtl/cache_fill_pkg.sv
// Shared types and geometry constants for the cache-miss fill controller.
package cache_fill_pkg;

   // 16-bit words per cache block; must be a power of two.
   localparam int unsigned BLOCK_WORDS   = 8;
   // Byte-offset field width of a block address (16 bytes -> 4 bits).
   localparam int unsigned OFFSET_BITS   = $clog2(2 * BLOCK_WORDS);
   // Width of the per-word issue/receive counters.
   localparam int unsigned WORD_CNT_BITS = $clog2(BLOCK_WORDS);

   // Controller states: idle (write-through forwarding) or block fill.
   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StFill = 1'b1
   } fill_state_e;

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Word counter used for both read issue and read-data receive during a block fill.
// Wraps at the block size; a sticky done flag records that the last word was counted,
// since a log2(BLOCK_WORDS)-bit counter alone cannot express "all words counted".
module fill_counter
   import cache_fill_pkg::*;
#(
   parameter int unsigned Width = WORD_CNT_BITS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [Width-1:0] cnt,
   output logic             tc,
   output logic             done
);

   logic [Width-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;

   // Next count: clear wins over increment; done latches on the terminal increment.
   always_comb begin
      cnt_d  = cnt_q;
      done_d = done_q;
      if (clr) begin
         cnt_d  = '0;
         done_d = 1'b0;
      end else if (inc) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == '1) begin
            done_d = 1'b1;
         end
      end
   end

   // Count and done registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign cnt  = cnt_q;
   assign tc   = (cnt_q == '1);
   assign done = done_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache-miss fill controller. On a miss, issues one pipelined word read per cycle for
// the aligned block, writes each returned word into the data array, and writes the tag
// with the last word. In idle it forwards single-word write-through requests to memory.
// All outputs are combinational from state, counters, base and inputs.
module cache_fill_fsm #(
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned BLOCK_WORDS = 8,
   parameter int unsigned MEM_LATENCY = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  miss_detected,
   input  logic [ADDR_WIDTH-1:0] miss_address,
   input  logic                  wr_req,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [15:0]           wr_data,
   input  logic [15:0]           memory_data,
   input  logic                  memory_data_valid,
   output logic                  mem_enable,
   output logic                  mem_wr,
   output logic [ADDR_WIDTH-1:0] memory_address,
   output logic [15:0]           memory_wdata,
   output logic                  wr_ack,
   output logic                  fsm_busy,
   output logic                  write_data_array,
   output logic [ADDR_WIDTH-1:0] fill_word_addr,
   output logic [15:0]           fill_data,
   output logic                  write_tag_array
);

   import cache_fill_pkg::*;

   localparam int unsigned CntBits = $clog2(BLOCK_WORDS);
   // Byte-offset bits within a block; cleared to form the block base.
   localparam logic [ADDR_WIDTH-1:0] OffMask = ADDR_WIDTH'(2 * BLOCK_WORDS - 1);

   // Memory latency is fixed by the memory; the FSM only reacts to data_valid.
   if (BLOCK_WORDS < 2 || MEM_LATENCY < 1) begin : g_param_check
      $error("cache_fill_fsm: BLOCK_WORDS must be >= 2 and MEM_LATENCY >= 1");
   end

   fill_state_e           state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;

   logic               cnt_clr;
   logic               issue_inc, recv_inc;
   logic [CntBits-1:0] issue_cnt, recv_cnt;
   logic               issue_tc, recv_tc;
   logic               issue_done, recv_done;

   logic [ADDR_WIDTH-1:0] issue_addr, recv_addr;

   // Issue counter: one read request per cycle until the block has been requested.
   fill_counter #(
      .Width (CntBits)
   ) u_issue_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .inc  (issue_inc),
      .cnt  (issue_cnt),
      .tc   (issue_tc),
      .done (issue_done)
   );

   // Receive counter: advances on each returned word.
   fill_counter #(
      .Width (CntBits)
   ) u_recv_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .inc  (recv_inc),
      .cnt  (recv_cnt),
      .tc   (recv_tc),
      .done (recv_done)
   );

   // Word byte addresses within the aligned block (no carry out of the offset field).
   assign issue_addr = base_q + {{(ADDR_WIDTH - CntBits - 1){1'b0}}, issue_cnt, 1'b0};
   assign recv_addr  = base_q + {{(ADDR_WIDTH - CntBits - 1){1'b0}}, recv_cnt, 1'b0};

   // Data paths are pure forwards.
   assign memory_wdata = wr_data;
   assign fill_data    = memory_data;

   // Next-state and output decode.
   always_comb begin
      state_d          = state_q;
      base_d           = base_q;
      cnt_clr          = 1'b0;
      issue_inc        = 1'b0;
      recv_inc         = 1'b0;
      mem_enable       = 1'b0;
      mem_wr           = 1'b0;
      memory_address   = '0;
      wr_ack           = 1'b0;
      fsm_busy         = 1'b0;
      write_data_array = 1'b0;
      fill_word_addr   = '0;
      write_tag_array  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (miss_detected) begin
               // Miss wins over a concurrent write-through; the writer holds its request.
               base_d  = miss_address & ~OffMask;
               cnt_clr = 1'b1;
               state_d = StFill;
            end else if (wr_req) begin
               mem_enable     = 1'b1;
               mem_wr         = 1'b1;
               memory_address = wr_addr;
               wr_ack         = 1'b1;
            end
         end

         StFill: begin
            fsm_busy = 1'b1;
            if (!issue_done) begin
               mem_enable     = 1'b1;
               memory_address = issue_addr;
               issue_inc      = 1'b1;
            end
            if (memory_data_valid && !recv_done) begin
               write_data_array = 1'b1;
               fill_word_addr   = recv_addr;
               recv_inc         = 1'b1;
               if (recv_tc) begin
                  write_tag_array = 1'b1;
                  state_d         = StIdle;
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and block base registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         base_q  <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
      end
   end

   // Issue terminal count is only consumed through the sticky done flag.
   logic unused_issue_tc;
   assign unused_issue_tc = issue_tc;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm. Drives directed and randomized misses and
// write-through requests, acts as a 4-cycle-latency memory by supplying read data in
// fill cycles 5-12, and checks outputs against a cycle-numbered model of a fill.
module tb_cache_fill_fsm;

   logic        clk;
   logic        rst;
   logic        miss_detected;
   logic [15:0] miss_address;
   logic        wr_req;
   logic [15:0] wr_addr;
   logic [15:0] wr_data;
   logic [15:0] memory_data;
   logic        memory_data_valid;
   logic        mem_enable;
   logic        mem_wr;
   logic [15:0] memory_address;
   logic [15:0] memory_wdata;
   logic        wr_ack;
   logic        fsm_busy;
   logic        write_data_array;
   logic [15:0] fill_word_addr;
   logic [15:0] fill_data;
   logic        write_tag_array;

   int errors = 0;
   int checks = 0;

   cache_fill_fsm #(
      .ADDR_WIDTH  (16),
      .BLOCK_WORDS (8),
      .MEM_LATENCY (4)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .miss_detected     (miss_detected),
      .miss_address      (miss_address),
      .wr_req            (wr_req),
      .wr_addr           (wr_addr),
      .wr_data           (wr_data),
      .memory_data       (memory_data),
      .memory_data_valid (memory_data_valid),
      .mem_enable        (mem_enable),
      .mem_wr            (mem_wr),
      .memory_address    (memory_address),
      .memory_wdata      (memory_wdata),
      .wr_ack            (wr_ack),
      .fsm_busy          (fsm_busy),
      .write_data_array  (write_data_array),
      .fill_word_addr    (fill_word_addr),
      .fill_data         (fill_data),
      .write_tag_array   (write_tag_array)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d",
               errors, checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // All control/address outputs at their reset values (inputs quiet).
   task automatic chk_quiet(input string tag);
      chk({tag, "_mem_en"}, 32'(mem_enable), 0);
      chk({tag, "_mem_wr"}, 32'(mem_wr), 0);
      chk({tag, "_mem_addr"}, 32'(memory_address), 0);
      chk({tag, "_wr_ack"}, 32'(wr_ack), 0);
      chk({tag, "_busy"}, 32'(fsm_busy), 0);
      chk({tag, "_wda"}, 32'(write_data_array), 0);
      chk({tag, "_fwa"}, 32'(fill_word_addr), 0);
      chk({tag, "_wta"}, 32'(write_tag_array), 0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One miss starting "now" (cycle 0). Model: base = addr rounded down to 16 bytes;
   // read i issued in cycle 1+i, word i returned and written in cycle 5+i, tag in 12.
   // Returns early right after the clock edge that starts cycle stop_k.
   task automatic run_miss(input logic [15:0] addr, input bit hold_wr,
                           input logic [15:0] waddr, input logic [15:0] wdata,
                           input int stop_k);
      logic [15:0] base;
      logic [15:0] words [8];
      logic [15:0] ea;
      base = addr - (addr % 16'd16);
      for (int i = 0; i < 8; i++) words[i] = 16'($urandom);

      miss_detected     = 1'b1;
      miss_address      = addr;
      wr_req            = hold_wr;
      wr_addr           = waddr;
      wr_data           = wdata;
      memory_data_valid = 1'b0;
      #1;
      chk("c0_busy", 32'(fsm_busy), 0);
      chk("c0_wr_ack", 32'(wr_ack), 0);
      chk("c0_mem_en", 32'(mem_enable), 0);

      for (int k = 1; k <= 12; k++) begin
         step();
         if (k == stop_k) return;
         // Misses during a fill must be ignored.
         miss_detected     = 1'($urandom);
         miss_address      = 16'($urandom);
         memory_data_valid = (k >= 5);
         memory_data       = (k >= 5) ? words[k-5] : 16'($urandom);
         #1;
         chk("fill_busy", 32'(fsm_busy), 1);
         chk("fill_wr_ack", 32'(wr_ack), 0);
         chk("fill_mem_wr", 32'(mem_wr), 0);
         chk("fill_mem_en", 32'(mem_enable), (k <= 8) ? 1 : 0);
         ea = (k <= 8) ? base + 16'(2 * (k - 1)) : 16'h0;
         chk("fill_mem_addr", 32'(memory_address), 32'(ea));
         chk("fill_wda", 32'(write_data_array), (k >= 5) ? 1 : 0);
         ea = (k >= 5) ? base + 16'(2 * (k - 5)) : 16'h0;
         chk("fill_fwa", 32'(fill_word_addr), 32'(ea));
         if (k >= 5) chk("fill_data", 32'(fill_data), 32'(words[k-5]));
         chk("fill_wta", 32'(write_tag_array), (k == 12) ? 1 : 0);
      end
      step();
      miss_detected     = 1'b0;
      memory_data_valid = 1'b0;
   endtask

   initial begin
      logic [15:0] a, d;
      rst               = 1'b1;
      miss_detected     = 1'b0;
      miss_address      = '0;
      wr_req            = 1'b0;
      wr_addr           = '0;
      wr_data           = '0;
      memory_data       = '0;
      memory_data_valid = 1'b0;
      #1;
      chk_quiet("reset");
      step();
      step();
      rst = 1'b0;
      #1;
      chk_quiet("post_reset");

      // Directed write-through in idle.
      wr_req  = 1'b1;
      wr_addr = 16'h0040;
      wr_data = 16'hBEEF;
      #1;
      chk("wt_mem_en", 32'(mem_enable), 1);
      chk("wt_mem_wr", 32'(mem_wr), 1);
      chk("wt_addr", 32'(memory_address), 32'h0040);
      chk("wt_wdata", 32'(memory_wdata), 32'hBEEF);
      chk("wt_ack", 32'(wr_ack), 1);
      chk("wt_busy", 32'(fsm_busy), 0);

      // Random write-throughs.
      for (int i = 0; i < 4; i++) begin
         step();
         a = 16'($urandom) & 16'hFFFE;
         d = 16'($urandom);
         wr_addr = a;
         wr_data = d;
         #1;
         chk("rwt_ack", 32'(wr_ack), 1);
         chk("rwt_mem_wr", 32'(mem_wr), 1);
         chk("rwt_addr", 32'(memory_address), 32'(a));
         chk("rwt_wdata", 32'(memory_wdata), 32'(d));
      end
      step();
      wr_req = 1'b0;
      #1;
      chk_quiet("wt_done");

      // Directed miss at 0x1236.
      step();
      run_miss(16'h1236, 1'b0, 16'h0, 16'h0, 0);
      #1;
      chk("m1_idle_busy", 32'(fsm_busy), 0);

      // Miss and write together: fill wins, write acked in cycle 13.
      step();
      run_miss(16'h2468, 1'b1, 16'h0100, 16'h1234, 0);
      #1;
      chk("mw_c13_ack", 32'(wr_ack), 1);
      chk("mw_c13_mem_wr", 32'(mem_wr), 1);
      chk("mw_c13_addr", 32'(memory_address), 32'h0100);
      chk("mw_c13_wdata", 32'(memory_wdata), 32'h1234);
      step();
      wr_req = 1'b0;

      // Top-of-memory block, then a back-to-back miss at 0x0000 in cycle 13.
      step();
      run_miss(16'hFFFE, 1'b0, 16'h0, 16'h0, 0);
      run_miss(16'h0000, 1'b0, 16'h0, 16'h0, 0);

      // Random misses, some back-to-back.
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) step();
         run_miss(16'($urandom), 1'b0, 16'h0, 16'h0, 0);
      end

      // Reset in cycle 7 of a fill; straggling valids afterwards are ignored.
      step();
      run_miss(16'h5A5A, 1'b0, 16'h0, 16'h0, 7);
      rst               = 1'b1;
      miss_detected     = 1'b0;
      memory_data_valid = 1'b1;
      memory_data       = 16'h7777;
      #1;
      chk_quiet("rst_mid");
      step();
      chk_quiet("rst_hold");
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("straggle_wda", 32'(write_data_array), 0);
         chk("straggle_wta", 32'(write_tag_array), 0);
         chk("straggle_busy", 32'(fsm_busy), 0);
         step();
      end
      memory_data_valid = 1'b0;
      run_miss(16'h3C3C, 1'b0, 16'h0, 16'h0, 0);

      // Lone valid pulses in idle.
      step();
      for (int i = 0; i < 3; i++) begin
         memory_data_valid = 1'b1;
         memory_data       = 16'($urandom);
         #1;
         chk("idle_valid_wda", 32'(write_data_array), 0);
         chk("idle_valid_fwa", 32'(fill_word_addr), 0);
         step();
         memory_data_valid = 1'b0;
         #1;
         chk("idle_valid_busy", 32'(fsm_busy), 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
